// File: rtl/button_gesture_decoder_pkg.sv
// Shared types and constants for the button gesture decoder.
package button_gesture_decoder_pkg;

    // Width of the shared timeout counter; covers up to 2^26-1 cycles.
    localparam int CNT_W = 26;

    // Gesture recogniser states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT_GAP  = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } gesture_state_t;

endpackage

// File: rtl/button_gesture_decoder_gesture_timer.sv
// Timeout counter for the gesture decoder: synchronous clear, count enable
// and a terminal-count compare against a caller-selected limit.
module gesture_timer
    import button_gesture_decoder_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Counter register: clear has priority over enable; the caller stops
    // enabling once tc is seen, so the count never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == terminal);

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced press/release strobes into single click, double click
// and long press gestures, with a hold level while a long press is held.
module button_gesture_decoder
    import button_gesture_decoder_pkg::*;
#(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_down,
    input  logic i_btn_up,
    output logic o_single,
    output logic o_double,
    output logic o_long,
    output logic o_hold,
    output logic o_busy
);

    // Terminal counts: the timeout fires when the counter reaches limit-1.
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

    gesture_state_t   state;
    gesture_state_t   state_nxt;
    logic             down_evt;
    logic             up_evt;
    logic             tmr_clear;
    logic             tmr_enable;
    logic             tmr_tc;
    logic [CNT_W-1:0] tmr_terminal;
    logic             single_nxt;
    logic             double_nxt;
    logic             long_nxt;

    // A press and a release in the same cycle cancel each other out.
    assign down_evt = i_btn_down & ~i_btn_up;
    assign up_evt   = i_btn_up & ~i_btn_down;

    // Only the gap wait uses the shorter limit; every other state times the hold.
    assign tmr_terminal = (state == WAIT_GAP) ? GAP_TC : LONG_TC;

    gesture_timer u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .clear    (tmr_clear),
        .enable   (tmr_enable),
        .terminal (tmr_terminal),
        .tc       (tmr_tc)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pulse decode; strobes are checked before timeouts so a
    // release beats the long timeout and a press beats the gap timeout.
    always_comb begin
        state_nxt  = state;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (down_evt) begin
                    state_nxt = PRESS1;
                    tmr_clear = 1'b1;
                end
            end
            PRESS1: begin
                if (up_evt) begin
                    state_nxt = WAIT_GAP;
                    tmr_clear = 1'b1;
                end else if (tmr_tc) begin
                    state_nxt = LONG_HELD;
                    long_nxt  = 1'b1;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            WAIT_GAP: begin
                if (down_evt) begin
                    state_nxt = PRESS2;
                    tmr_clear = 1'b1;
                end else if (tmr_tc) begin
                    state_nxt  = IDLE;
                    single_nxt = 1'b1;
                    tmr_clear  = 1'b1;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            PRESS2: begin
                if (up_evt) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                    tmr_clear  = 1'b1;
                end else if (tmr_tc) begin
                    // The pending first click is dropped in favour of the long press.
                    state_nxt = LONG_HELD;
                    long_nxt  = 1'b1;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            LONG_HELD: begin
                if (up_evt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_clear = 1'b1;
            end
        endcase
    end

    // Registered one-cycle gesture pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_single <= 1'b0;
            o_double <= 1'b0;
            o_long   <= 1'b0;
        end else begin
            o_single <= single_nxt;
            o_double <= double_nxt;
            o_long   <= long_nxt;
        end
    end

    // Status levels come straight from the state register.
    assign o_hold = (state == LONG_HELD);
    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder: directed gestures plus random strobes,
// checked every cycle against a timestamp-based gesture model.
module tb_button_gesture_decoder;

    localparam int LONG = 8;
    localparam int GAP  = 4;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_btn_down = 1'b0;
    logic i_btn_up = 1'b0;
    logic o_single, o_double, o_long, o_hold, o_busy;

    int n_assert = 0;
    int n_fail = 0;

    // Model: button held?, completed clicks awaiting a decision, long press
    // active, and the edge index at which the current timed interval began.
    bit m_held, m_long_on, m_single, m_double, m_long;
    int m_clicks, m_since, cyc;

    // Tallies over a scenario.
    int t_single, t_double, t_long, t_busy;

    button_gesture_decoder #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_btn_down (i_btn_down),
        .i_btn_up   (i_btn_up),
        .o_single   (o_single),
        .o_double   (o_double),
        .o_long     (o_long),
        .o_hold     (o_hold),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_edge(input bit d, input bit u, input bit r);
        bit dn, up;
        m_single = 0; m_double = 0; m_long = 0;
        dn = d && !u;
        up = u && !d;
        if (!r) begin
            m_held = 0; m_clicks = 0; m_long_on = 0; m_since = cyc;
        end else if (m_long_on) begin
            if (up) begin m_long_on = 0; m_held = 0; end
        end else if (m_held) begin
            if (up) begin
                m_held = 0;
                if (m_clicks == 1) begin m_double = 1; m_clicks = 0; end
                else begin m_clicks = 1; m_since = cyc; end
            end else if (cyc - m_since == LONG) begin
                m_long = 1; m_long_on = 1; m_clicks = 0;
            end
        end else if (m_clicks == 1) begin
            if (dn) begin m_held = 1; m_since = cyc; end
            else if (cyc - m_since == GAP) begin m_single = 1; m_clicks = 0; end
        end else if (dn) begin
            m_held = 1; m_since = cyc;
        end
    endtask

    task automatic step(input bit d, input bit u, input bit r);
        logic [4:0] obs, exp;
        i_btn_down = d;
        i_btn_up   = u;
        i_rst_n    = r;
        @(posedge i_clk);
        cyc++;
        model_edge(d, u, r);
        #1;
        exp = {m_single, m_double, m_long, m_long_on, m_held || m_long_on || (m_clicks != 0)};
        obs = {o_single, o_double, o_long, o_hold, o_busy};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL outputs cyc=%0d {single,double,long,hold,busy} observed=%b expected=%b", cyc, obs, exp);
        end
        t_single += int'(o_single);
        t_double += int'(o_double);
        t_long   += int'(o_long);
        t_busy   += int'(o_busy);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Plays a gesture whose strobes occur at given step indices (-1 = unused).
    task automatic play(input int len, input int dn_a, input int dn_b,
                        input int up_a, input int up_b, input int rst_at);
        step(0, 0, 0);
        step(0, 0, 1);
        t_single = 0; t_double = 0; t_long = 0; t_busy = 0;
        for (int i = 0; i < len; i++) begin
            step(i == dn_a || i == dn_b, i == up_a || i == up_b, i != rst_at);
        end
    endtask

    initial begin
        cyc = 0;
        m_held = 0; m_long_on = 0; m_clicks = 0; m_since = 0;

        // Reset state.
        step(0, 0, 0);
        step(0, 0, 0);
        check("reset_outputs", int'({o_single, o_double, o_long, o_hold, o_busy}), 0);

        // Single click.
        play(16, 0, -1, 3, -1, -1);
        check("single_cnt", t_single, 1);
        check("single_no_double", t_double, 0);
        check("single_no_long", t_long, 0);
        check("single_idle_end", int'(o_busy), 0);

        // Double click.
        play(16, 0, 4, 2, 6, -1);
        check("double_cnt", t_double, 1);
        check("double_no_single", t_single, 0);

        // Long press held then released.
        play(26, 0, -1, 20, -1, -1);
        check("long_cnt", t_long, 1);
        check("long_no_single", t_single, 0);
        check("long_idle_end", int'(o_busy), 0);

        // Release on the same edge as the long timeout.
        play(20, 0, -1, 8, -1, -1);
        check("tie_no_long", t_long, 0);
        check("tie_single", t_single, 1);

        // Second press held into a long press.
        play(20, 0, 4, 2, -1, -1);
        check("p2long_cnt", t_long, 1);
        check("p2long_no_double", t_double, 0);
        check("p2long_no_single", t_single, 0);

        // Reset mid-gesture.
        play(31, 0, -1, -1, -1, 3);
        check("rst_mid_pulses", t_single + t_double + t_long, 0);

        // Simultaneous strobes in IDLE, then a stray release.
        play(8, 0, -1, 0, 1, -1);
        check("simul_pulses", t_single + t_double + t_long, 0);
        check("simul_busy", t_busy, 0);

        // Random strobes with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(199) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
